butterfly_r4_pipe: RTL and testbench

// Pipelined, parametrised radix-4 DIT butterfly for the FFT datapath. Each accepted beat

---
 rtl/butterfly_r4_pipe.sv | 199 +++++++++++++++++++
 tb/tb_butterfly_r4_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_r4_pipe.sv
// butterfly_r4_pipe
// Three-stage pipelined radix-4 DIT butterfly with valid/ready flow control.
//   S1: twiddle multiply of B, C, D (rounded to DW+1 bits), A sign-extended
//   S2: first add/sub layer T0..T3 (DW+2 bits)
//   S3: second add/sub layer X0..X3 (DW+3 bits), optional /4 rounding, saturation
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   calc_in               {D,C,B,A} each (Re,Im), A.Im in LSBs
//   tw_in                 {Wd,Wc,Wb} each (Re,Im), Wb.Im in LSBs, Q1.(TW-2)
//   scale_en              beat travels with a /4 rounding request
//   out_valid / out_ready output beat handshake
//   calc_out              {X3,X2,X1,X0} each (Re,Im), X0.Im in LSBs
//   out_sat               some output component of this beat was clipped
module butterfly_r4_pipe #(
  parameter int DW = 17,
  parameter int TW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*DW-1:0] calc_in,
  input  logic [6*TW-1:0] tw_in,
  input  logic            scale_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*DW-1:0] calc_out,
  output logic            out_sat
);

  localparam int FRAC = TW - 2;
  localparam int PW   = DW + TW + 1;
  localparam int S1W  = DW + 1;
  localparam int S2W  = DW + 2;
  localparam int S3W  = DW + 3;

  localparam logic signed [PW-1:0]  RND  = PW'(1 << (FRAC - 1));
  localparam logic signed [S3W-1:0] TWO  = S3W'(2);
  localparam logic signed [S3W-1:0] MAXV = S3W'((1 << (DW - 1)) - 1);
  localparam logic signed [S3W-1:0] MINV = S3W'(-(1 << (DW - 1)));

  // Complex multiply at full precision, round half up, keep DW+1 bits.
  function automatic logic [2*S1W-1:0] cmul(input logic signed [DW-1:0] xr,
                                            input logic signed [DW-1:0] xi,
                                            input logic signed [TW-1:0] wr,
                                            input logic signed [TW-1:0] wi);
    logic signed [PW-1:0] xr_e, xi_e, wr_e, wi_e, pre, pim;
    xr_e = {{(PW-DW){xr[DW-1]}}, xr};
    xi_e = {{(PW-DW){xi[DW-1]}}, xi};
    wr_e = {{(PW-TW){wr[TW-1]}}, wr};
    wi_e = {{(PW-TW){wi[TW-1]}}, wi};
    pre  = xr_e * wr_e - xi_e * wi_e + RND;
    pim  = xr_e * wi_e + xi_e * wr_e + RND;
    return {S1W'(pre >>> FRAC), S1W'(pim >>> FRAC)};
  endfunction

  // Optional /4 with rounding, then clip; MSB of the result flags a clip.
  function automatic logic [DW:0] conv(input logic signed [S3W-1:0] v, input logic sc);
    logic signed [S3W-1:0] s;
    s = sc ? ((v + TWO) >>> 2) : v;
    if (s > MAXV) return {1'b1, MAXV[DW-1:0]};
    if (s < MINV) return {1'b1, MINV[DW-1:0]};
    return {1'b0, DW'(s)};
  endfunction

  function automatic logic [S2W-1:0] re1(input logic [2*S1W-1:0] x);
    return {x[2*S1W-1], x[2*S1W-1:S1W]};
  endfunction

  function automatic logic [S2W-1:0] im1(input logic [2*S1W-1:0] x);
    return {x[S1W-1], x[S1W-1:0]};
  endfunction

  function automatic logic [S3W-1:0] re2(input logic [2*S2W-1:0] x);
    return {x[2*S2W-1], x[2*S2W-1:S2W]};
  endfunction

  function automatic logic [S3W-1:0] im2(input logic [2*S2W-1:0] x);
    return {x[S2W-1], x[S2W-1:0]};
  endfunction

  logic                 en;
  logic                 s1_valid_q, s1_valid_d, s1_scale_q, s1_scale_d;
  logic [2*S1W-1:0]     s1_x_q [4];
  logic [2*S1W-1:0]     s1_x_d [4];
  logic                 s2_valid_q, s2_valid_d, s2_scale_q, s2_scale_d;
  logic [2*S2W-1:0]     s2_t_q [4];
  logic [2*S2W-1:0]     s2_t_d [4];
  logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [8*DW-1:0]      calc_out_q, calc_out_d;
  logic signed [S3W-1:0] x_re [4];
  logic signed [S3W-1:0] x_im [4];
  logic [DW:0]          cv_re [4];
  logic [DW:0]          cv_im [4];

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign calc_out  = calc_out_q;
  assign out_sat   = out_sat_q;

  // Stage 1: inputs are sampled only when a beat is accepted.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_scale_d = s1_scale_q;
    for (int i = 0; i < 4; i++) s1_x_d[i] = s1_x_q[i];
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_scale_d = scale_en;
        s1_x_d[0]  = {calc_in[2*DW-1], calc_in[2*DW-1:DW], calc_in[DW-1], calc_in[DW-1:0]};
        for (int n = 1; n < 4; n++)
          s1_x_d[n] = cmul(calc_in[(2*n+1)*DW +: DW], calc_in[2*n*DW +: DW],
                           tw_in[(2*n-1)*TW +: TW], tw_in[(2*n-2)*TW +: TW]);
      end
    end
  end

  // Stage 2: T0=A+C', T1=A-C', T2=B'+D', T3=B'-D'.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_scale_d = s2_scale_q;
    for (int i = 0; i < 4; i++) s2_t_d[i] = s2_t_q[i];
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_scale_d = s1_scale_q;
      s2_t_d[0]  = {re1(s1_x_q[0]) + re1(s1_x_q[2]), im1(s1_x_q[0]) + im1(s1_x_q[2])};
      s2_t_d[1]  = {re1(s1_x_q[0]) - re1(s1_x_q[2]), im1(s1_x_q[0]) - im1(s1_x_q[2])};
      s2_t_d[2]  = {re1(s1_x_q[1]) + re1(s1_x_q[3]), im1(s1_x_q[1]) + im1(s1_x_q[3])};
      s2_t_d[3]  = {re1(s1_x_q[1]) - re1(s1_x_q[3]), im1(s1_x_q[1]) - im1(s1_x_q[3])};
    end
  end

  // Stage 3 arithmetic: the -j / +j rotations of T3 swap Re/Im with a sign flip.
  always_comb begin
    x_re[0] = re2(s2_t_q[0]) + re2(s2_t_q[2]);
    x_im[0] = im2(s2_t_q[0]) + im2(s2_t_q[2]);
    x_re[2] = re2(s2_t_q[0]) - re2(s2_t_q[2]);
    x_im[2] = im2(s2_t_q[0]) - im2(s2_t_q[2]);
    x_re[1] = re2(s2_t_q[1]) + im2(s2_t_q[3]);
    x_im[1] = im2(s2_t_q[1]) - re2(s2_t_q[3]);
    x_re[3] = re2(s2_t_q[1]) - im2(s2_t_q[3]);
    x_im[3] = im2(s2_t_q[1]) + re2(s2_t_q[3]);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cv_re[k] = conv(x_re[k], s2_scale_q);
      cv_im[k] = conv(x_im[k], s2_scale_q);
    end
  end

  // Output register; bubbles load don't-care data, qualified by out_valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    calc_out_d  = calc_out_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_sat_d   = 1'b0;
      for (int k = 0; k < 4; k++) begin
        calc_out_d[(2*k+1)*DW +: DW] = cv_re[k][DW-1:0];
        calc_out_d[2*k*DW +: DW]     = cv_im[k][DW-1:0];
        out_sat_d = out_sat_d | cv_re[k][DW] | cv_im[k][DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_scale_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_scale_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      calc_out_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        s1_x_q[i] <= '0;
        s2_t_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      s2_scale_q  <= s2_scale_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      calc_out_q  <= calc_out_d;
      for (int i = 0; i < 4; i++) begin
        s1_x_q[i] <= s1_x_d[i];
        s2_t_q[i] <= s2_t_d[i];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_r4_pipe.sv
// tb_butterfly_r4_pipe
// Directed-vector bench for butterfly_r4_pipe (DW=17, TW=9). A plain integer
// model of the radix-4 butterfly predicts every accepted beat; a negedge
// monitor compares each valid output against the oldest prediction.
module tb_butterfly_r4_pipe;

  localparam int DW = 17;
  localparam int TW = 9;
  localparam int FRAC = TW - 2;
  localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW - 1));

  typedef logic [8*DW-1:0] data_t;
  typedef logic [6*TW-1:0] tw_t;

  logic        clk, rst, in_valid, in_ready, scale_en, out_valid, out_ready, out_sat;
  data_t       calc_in, calc_out;
  tw_t         tw_in;

  int          nVec = 0;
  int          nErr = 0;
  int          popCount = 0;
  logic [8*DW:0] expQ [$];

  butterfly_r4_pipe #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .calc_in(calc_in), .tw_in(tw_in), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .calc_out(calc_out), .out_sat(out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic data_t mkData(int ar, int ai, int br, int bi, int cr, int ci, int dr, int di);
    return {DW'(dr), DW'(di), DW'(cr), DW'(ci), DW'(br), DW'(bi), DW'(ar), DW'(ai)};
  endfunction

  function automatic tw_t mkTw(int br, int bi, int cr, int ci, int dr, int di);
    return {TW'(dr), TW'(di), TW'(cr), TW'(ci), TW'(br), TW'(bi)};
  endfunction

  function automatic int getRe(data_t v, int k);
    int r;
    r = $signed(v[(2*k+1)*DW +: DW]);
    return r;
  endfunction

  function automatic int getIm(data_t v, int k);
    int r;
    r = $signed(v[2*k*DW +: DW]);
    return r;
  endfunction

  // Reference butterfly in plain integer arithmetic: returns {sat, X3..X0}.
  function automatic logic [8*DW:0] model(data_t d, tw_t w, logic sc);
    longint xr [4], xi [4];
    longint wr, wi, pr, pi, v;
    longint t0r, t0i, t1r, t1i, t2r, t2i, t3r, t3i;
    longint yr [4], yi [4];
    data_t  o;
    logic   sat;
    for (int n = 0; n < 4; n++) begin
      xr[n] = $signed(d[(2*n+1)*DW +: DW]);
      xi[n] = $signed(d[2*n*DW +: DW]);
    end
    for (int n = 1; n < 4; n++) begin
      wr = $signed(w[(2*n-1)*TW +: TW]);
      wi = $signed(w[(2*n-2)*TW +: TW]);
      pr = xr[n] * wr - xi[n] * wi;
      pi = xr[n] * wi + xi[n] * wr;
      xr[n] = (pr + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      xi[n] = (pi + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    end
    t0r = xr[0] + xr[2];  t0i = xi[0] + xi[2];
    t1r = xr[0] - xr[2];  t1i = xi[0] - xi[2];
    t2r = xr[1] + xr[3];  t2i = xi[1] + xi[3];
    t3r = xr[1] - xr[3];  t3i = xi[1] - xi[3];
    yr[0] = t0r + t2r;    yi[0] = t0i + t2i;
    yr[2] = t0r - t2r;    yi[2] = t0i - t2i;
    yr[1] = t1r + t3i;    yi[1] = t1i - t3r;
    yr[3] = t1r - t3i;    yi[3] = t1i + t3r;
    sat = 1'b0;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        v = (p == 1) ? yr[k] : yi[k];
        if (sc) v = (v + 2) >>> 2;
        if (v > MAXV) begin v = MAXV; sat = 1'b1; end
        else if (v < MINV) begin v = MINV; sat = 1'b1; end
        o[(2*k+p)*DW +: DW] = v[DW-1:0];
      end
    end
    return {sat, o};
  endfunction

  // Scoreboard: every valid output must equal the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
    end else begin
      if (out_valid) begin
        nVec++;
        if (expQ.size() == 0) begin
          nErr++;
          $display("[TB] FAIL scoreboard: unexpected output sat=%0b data=%h, none expected", out_sat, calc_out);
        end else if ({out_sat, calc_out} !== expQ[0]) begin
          nErr++;
          $display("[TB] FAIL scoreboard: got sat=%0b data=%h, expected sat=%0b data=%h",
                   out_sat, calc_out, expQ[0][8*DW], expQ[0][8*DW-1:0]);
        end
        if (out_ready && expQ.size() > 0) begin
          void'(expQ.pop_front());
          popCount++;
        end
      end
      if (in_valid && in_ready) expQ.push_back(model(calc_in, tw_in, scale_en));
    end
  end

  task automatic checkOutput(input string name, input int k, input int expRe, input int expIm);
    nVec++;
    if (getRe(calc_out, k) != expRe || getIm(calc_out, k) != expIm) begin
      nErr++;
      $display("[TB] FAIL %s: X%0d got (%0d,%0d), expected (%0d,%0d)", name, k,
               getRe(calc_out, k), getIm(calc_out, k), expRe, expIm);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    nVec++;
    if (got != exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input data_t d, input tw_t w, input logic sc);
    int n;
    n = 0;
    calc_in  = d;
    tw_in    = w;
    scale_en = sc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkBit("accept within bound", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    calc_in  = '1;
    tw_in    = '1;
    scale_en = 1'b1;
  endtask

  task automatic waitOut(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkBit(name, out_valid, 1'b1);
  endtask

  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  tw_t           w1;
  data_t         big;
  logic [8*DW:0] m;

  initial begin
    w1 = mkTw(128, 0, 128, 0, 128, 0);
    big = mkData(65535, -65536, 65535, -65536, 65535, -65536, 65535, -65536);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    calc_in = '0; tw_in = '0; scale_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkBit("reset out_valid", out_valid, 1'b0);
    checkBit("reset out_sat", out_sat, 1'b0);
    checkBit("reset in_ready", in_ready, 1'b1);
    checkOutput("reset calc_out", 0, 0, 0);
    checkOutput("reset calc_out", 3, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    syncEdge();

    // Model pins against hand-computed values.
    m = model(mkData(0, 0, 100, 0, 0, 0, 0, 0), mkTw(91, -91, 128, 0, 128, 0), 1'b0);
    checkInt("model rounding re", getRe(m[8*DW-1:0], 0), 71);
    checkInt("model rounding im", getIm(m[8*DW-1:0], 0), -71);
    m = model(big, w1, 1'b0);
    checkInt("model sat flag", int'(m[8*DW]), 1);
    m = model(big, w1, 1'b1);
    checkInt("model scaled X0 im", getIm(m[8*DW-1:0], 0), -65536);

    // Test 1: unity twiddles, equal inputs.
    applyStimulus(mkData(100, 0, 100, 0, 100, 0, 100, 0), w1, 1'b0);
    waitOut("t1 out_valid");
    checkOutput("t1", 0, 400, 0);
    checkOutput("t1", 1, 0, 0);
    checkOutput("t1", 2, 0, 0);
    checkOutput("t1", 3, 0, 0);
    checkBit("t1 sat", out_sat, 1'b0);
    syncEdge();

    // Test 2: Wb = -j.
    applyStimulus(mkData(0, 0, 100, 0, 0, 0, 0, 0), mkTw(0, -128, 128, 0, 128, 0), 1'b0);
    waitOut("t2 out_valid");
    checkOutput("t2", 0, 0, -100);
    checkOutput("t2", 1, -100, 0);
    checkOutput("t2", 2, 0, 100);
    checkOutput("t2", 3, 100, 0);
    syncEdge();

    // Test 3: rounding of the twiddle product.
    applyStimulus(mkData(0, 0, 100, 0, 0, 0, 0, 0), mkTw(91, -91, 128, 0, 128, 0), 1'b0);
    waitOut("t3 out_valid");
    checkOutput("t3", 0, 71, -71);
    checkOutput("t3", 2, -71, 71);
    syncEdge();

    // Test 4: saturation without and with scaling.
    applyStimulus(big, w1, 1'b0);
    waitOut("t4a out_valid");
    checkOutput("t4a", 0, 65535, -65536);
    checkOutput("t4a", 1, 0, 0);
    checkBit("t4a sat", out_sat, 1'b1);
    syncEdge();
    applyStimulus(big, w1, 1'b1);
    waitOut("t4b out_valid");
    checkOutput("t4b", 0, 65535, -65536);
    checkBit("t4b sat", out_sat, 1'b0);
    syncEdge();

    // Test 5: six back-to-back beats with a five-cycle output stall.
    popCount = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          applyStimulus(mkData(i, 0, 10 * i, -i, 0, 0, 3, i), w1, 1'b0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        syncEdge();
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkBit("t5 in_ready during stall", in_ready, 1'b0);
          checkBit("t5 out_valid during stall", out_valid, 1'b1);
        end
        syncEdge();
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 40 && expQ.size() > 0; n++) @(negedge clk);
    checkInt("t5 queue drained", expQ.size(), 0);
    checkInt("t5 beats delivered", popCount, 6);
    syncEdge();

    // Test 6: asynchronous reset with beats in flight.
    applyStimulus(mkData(7, 1, 0, 0, 0, 0, 0, 0), w1, 1'b0);
    applyStimulus(mkData(8, 2, 0, 0, 0, 0, 0, 0), w1, 1'b0);
    applyStimulus(mkData(9, 3, 0, 0, 0, 0, 0, 0), w1, 1'b0);
    checkBit("t6 out_valid before reset", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkBit("t6 out_valid in reset", out_valid, 1'b0);
    checkBit("t6 in_ready in reset", in_ready, 1'b1);
    checkOutput("t6 calc_out in reset", 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkBit("t6 in_ready after release", in_ready, 1'b1);
    syncEdge();
    applyStimulus(mkData(50, 0, 0, 0, 0, 0, 0, 0), w1, 1'b0);
    @(negedge clk);
    checkBit("t6 latency cycle 1", out_valid, 1'b0);
    @(negedge clk);
    checkBit("t6 latency cycle 2", out_valid, 1'b0);
    @(negedge clk);
    checkBit("t6 latency cycle 3", out_valid, 1'b1);
    checkOutput("t6", 0, 50, 0);
    checkOutput("t6", 1, 50, 0);
    checkOutput("t6", 2, 50, 0);
    checkOutput("t6", 3, 50, 0);

    for (int n = 0; n < 20 && expQ.size() > 0; n++) @(negedge clk);
    checkInt("final queue drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", nVec, nErr);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
